// File: rtl/clock_tick_controller.sv
// Clock-enable sequencer: one-cycle tick every P clock_in cycles, with free-run, halt and N-tick step.
// Optional tick_count output enabled by defining CLOCK_TICK_COUNT_EN.
//
// state | meaning
// IDLE  | halted, no ticks, counter held; step and config accepted
// RUN   | free-running ticks while run is high
// STEP  | issuing a fixed number of ticks, run ignored until done
module clock_tick_controller #(
    parameter int DIV_SIZE    = 15,
    parameter int DEFAULT_DIV = 24000,
    parameter int STEP_W      = 8
) (
    input  logic                clock_in,
    input  logic                reset_n,
    input  logic                run,
    input  logic                cfg_valid,
    input  logic [DIV_SIZE-1:0] cfg_div,
    output logic                cfg_ready,
    input  logic                step_valid,
    input  logic [STEP_W-1:0]   step_count,
    output logic                step_ready,
    output logic                tick,
    output logic                busy,
    output logic [DIV_SIZE-1:0] cur_div,
`ifdef CLOCK_TICK_COUNT_EN
    output logic [31:0]         tick_count,
`endif
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [DIV_SIZE-1:0] DEF_DIV = DIV_SIZE'(DEFAULT_DIV);
    localparam logic [DIV_SIZE-1:0] DIV_ONE = DIV_SIZE'(1);
    localparam logic [STEP_W-1:0]   STEP_ONE = STEP_W'(1);

    state_t              st;
    logic [DIV_SIZE-1:0] cnt;
    logic [DIV_SIZE-1:0] pend_div;
    logic                pend_valid;
    logic [STEP_W-1:0]   remaining;

    logic                apply_cfg;
    logic [DIV_SIZE-1:0] div_now;
    logic [DIV_SIZE-1:0] period_m1;
    logic                wrap;
    logic [DIV_SIZE-1:0] cnt_inc;

    // A pending period lands in IDLE at once, otherwise on the edge closing a tick cycle;
    // that edge already counts with the new period so the next tick is P_new after the last one.
    assign apply_cfg = pend_valid && ((st == IDLE) || tick);
    assign div_now   = apply_cfg ? pend_div : cur_div;
    assign period_m1 = (div_now == '0) ? '0 : (div_now - DIV_ONE);
    assign wrap      = (cnt >= period_m1);
    assign cnt_inc   = wrap ? '0 : (cnt + DIV_ONE);

    assign cfg_ready  = !pend_valid;
    assign step_ready = (st == IDLE) && !run;
    assign busy       = (st == STEP);
    assign state      = st;

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            st         <= IDLE;
            cnt        <= '0;
            tick       <= 1'b0;
            cur_div    <= DEF_DIV;
            pend_div   <= '0;
            pend_valid <= 1'b0;
            remaining  <= '0;
        end else begin
            if (apply_cfg) begin
                cur_div    <= div_now;
                pend_valid <= 1'b0;
            end else if (cfg_valid && cfg_ready) begin
                pend_div   <= (cfg_div == '0) ? DIV_ONE : cfg_div;
                pend_valid <= 1'b1;
            end

            tick <= 1'b0;
            case (st)
                IDLE: begin
                    if (run) begin
                        st  <= RUN;
                        cnt <= '0;
                    end else if (step_valid && (step_count != '0)) begin
                        st        <= STEP;
                        cnt       <= '0;
                        remaining <= step_count;
                    end
                end
                RUN: begin
                    if (!run) begin
                        st  <= IDLE;
                        cnt <= '0;
                    end else begin
                        cnt  <= cnt_inc;
                        tick <= wrap;
                    end
                end
                STEP: begin
                    if (tick && (remaining == '0)) begin
                        // Going straight to RUN keeps the tick grid of the step sequence.
                        if (run) begin
                            st   <= RUN;
                            cnt  <= cnt_inc;
                            tick <= wrap;
                        end else begin
                            st <= IDLE;
                        end
                    end else begin
                        cnt <= cnt_inc;
                        if (wrap) begin
                            tick      <= 1'b1;
                            remaining <= remaining - STEP_ONE;
                        end
                    end
                end
                default: begin
                    st  <= IDLE;
                    cnt <= '0;
                end
            endcase
        end
    end

`ifdef CLOCK_TICK_COUNT_EN
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            tick_count <= '0;
        end else if (tick) begin
            tick_count <= tick_count + 32'd1;
        end
    end
`endif

endmodule
